// File: rtl/oled_pkg.sv
// Shared types and constants for the OLED frame streamer: FSM states,
// SSD1306 window-set command bytes and small header/size helpers.
package oled_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA,
        FINISH
    } state_t;

    localparam logic [7:0] SET_COL  = 8'h21;
    localparam logic [7:0] SET_PAGE = 8'h22;
    localparam int         HDR_LEN  = 6;
    localparam int         CNT_W    = 11;

    // Number of framebuffer bytes covered by an inclusive window (1..1024).
    function automatic logic [CNT_W-1:0] frame_bytes(
        input logic [6:0] cs,
        input logic [6:0] ce,
        input logic [2:0] ps,
        input logic [2:0] pe
    );
        logic [CNT_W-1:0] cols;
        logic [CNT_W-1:0] pages;
        cols  = CNT_W'(ce) - CNT_W'(cs) + CNT_W'(1);
        pages = CNT_W'(pe) - CNT_W'(ps) + CNT_W'(1);
        return cols * pages;
    endfunction

    // Header byte for a given index: SET_COL, cs, ce, SET_PAGE, ps, pe.
    function automatic logic [7:0] hdr_byte(
        input logic [2:0] idx,
        input logic [6:0] cs,
        input logic [6:0] ce,
        input logic [2:0] ps,
        input logic [2:0] pe
    );
        logic [7:0] b;
        case (idx)
            3'd0:    b = SET_COL;
            3'd1:    b = {1'b0, cs};
            3'd2:    b = {1'b0, ce};
            3'd3:    b = SET_PAGE;
            3'd4:    b = {5'b0, ps};
            default: b = {5'b0, pe};
        endcase
        return b;
    endfunction

endpackage

// File: rtl/oled_byte_fifo.sv
// Two-entry FIFO of {dc, data} bytes. When empty, a write falls straight
// through to the output so a byte returned by the RAM can be offered in the
// same cycle it arrives; an unaccepted byte is captured and held.
module oled_byte_fifo (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [8:0] wr_data,
    input  logic       rd_en,
    output logic       rd_valid,
    output logic [8:0] rd_data,
    output logic [1:0] count
);

    logic [8:0] mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic       empty;
    logic       do_store;
    logic       do_drop;

    assign empty    = (count == 2'd0);
    assign rd_valid = !empty || wr_en;
    assign rd_data  = empty ? wr_data : mem[rd_ptr];
    // A write consumed directly through the bypass is never stored.
    assign do_store = wr_en && !(empty && rd_en);
    assign do_drop  = rd_en && !empty;

    // Capture incoming bytes into the slot at the write pointer.
    // NOTE: storage is deliberately not reset; occupancy is tracked by count,
    // so stale contents are never observed and the array stays plain RAM.
    always_ff @(posedge clk) begin
        if (do_store) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Advance pointers and occupancy on stores and pops.
    // NOTE: sequential state uses non-blocking assignments so every register
    // in the block updates from pre-edge values, whatever the statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_store) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_drop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_store} - {1'b0, do_drop};
        end
    end

endmodule

// File: rtl/oled_frame_streamer.sv
// Streams an SSD1306 window-set header (DC=0) followed by the matching
// framebuffer bytes (DC=1) to the SPI byte shifter, owning chip-select for
// the whole transfer.
module oled_frame_streamer
    import oled_pkg::*;
#(
    parameter int WIDTH     = 128,
    parameter int PAGES     = 8,
    parameter int FB_ADDR_W = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [6:0]           col_start,
    input  logic [6:0]           col_end,
    input  logic [2:0]           page_start,
    input  logic [2:0]           page_end,
    output logic                 fb_rd,
    output logic [FB_ADDR_W-1:0] fb_addr,
    input  logic [7:0]           fb_rdata,
    output logic                 byte_valid,
    input  logic                 byte_ready,
    output logic [7:0]           byte_data,
    output logic                 byte_dc,
    output logic                 oled_cs,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    state_t           state;
    logic [2:0]       hdr_idx;
    logic [6:0]       win_cs;
    logic [6:0]       win_ce;
    logic [2:0]       win_ps;
    logic [2:0]       win_pe;
    logic [6:0]       col;
    logic [2:0]       page;
    logic [CNT_W-1:0] reads_left;
    logic             rd_inflight;

    logic             window_bad;
    logic             hs;
    logic [2:0]       fifo_occ;
    logic             space_ok;
    logic             last_byte;

    logic             fifo_valid;
    logic [8:0]       fifo_rdata;
    logic [1:0]       fifo_count;
    logic             fifo_rd_en;

    assign window_bad = (col_start > col_end) || (page_start > page_end) ||
                        (int'(col_end) >= WIDTH) || (int'(page_end) >= PAGES);

    assign hs = byte_valid && byte_ready;

    // Space accounting covers both held bytes and the read whose data is
    // arriving now, so a read issued this cycle always has a slot.
    assign fifo_occ  = {1'b0, fifo_count} + {2'b0, rd_inflight};
    assign space_ok  = (fifo_occ <= 3'd1);
    assign last_byte = (reads_left == '0) && hs && (fifo_occ == 3'd1);

    assign fb_rd   = (state == DATA) && (reads_left != '0) && space_ok;
    assign fb_addr = FB_ADDR_W'(page) * FB_ADDR_W'(WIDTH) + FB_ADDR_W'(col);

    oled_byte_fifo u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (rd_inflight),
        .wr_data  ({1'b1, fb_rdata}),
        .rd_en    (fifo_rd_en),
        .rd_valid (fifo_valid),
        .rd_data  (fifo_rdata),
        .count    (fifo_count)
    );

    // Select the offered byte: header bytes in HDR, FIFO head in DATA.
    // NOTE: every output gets a default before the case, so no path through
    // this block leaves a signal unassigned and no latch is inferred.
    always_comb begin
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        byte_dc    = 1'b0;
        fifo_rd_en = 1'b0;
        case (state)
            HDR: begin
                byte_valid = 1'b1;
                byte_data  = hdr_byte(hdr_idx, win_cs, win_ce, win_ps, win_pe);
            end
            DATA: begin
                byte_valid = fifo_valid;
                byte_data  = fifo_rdata[7:0];
                byte_dc    = fifo_rdata[8];
                fifo_rd_en = fifo_valid && byte_ready;
            end
            default: ;
        endcase
    end

    // Control FSM with window latch, address walk and registered status.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            hdr_idx     <= 3'd0;
            win_cs      <= '0;
            win_ce      <= '0;
            win_ps      <= '0;
            win_pe      <= '0;
            col         <= '0;
            page        <= '0;
            reads_left  <= '0;
            rd_inflight <= 1'b0;
            oled_cs     <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done        <= 1'b0;
            err         <= 1'b0;
            rd_inflight <= fb_rd;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (window_bad) begin
                            err <= 1'b1;
                        end else begin
                            win_cs     <= col_start;
                            win_ce     <= col_end;
                            win_ps     <= page_start;
                            win_pe     <= page_end;
                            col        <= col_start;
                            page       <= page_start;
                            reads_left <= frame_bytes(col_start, col_end,
                                                      page_start, page_end);
                            hdr_idx    <= 3'd0;
                            oled_cs    <= 1'b0;
                            busy       <= 1'b1;
                            state      <= HDR;
                        end
                    end
                end
                HDR: begin
                    if (hs) begin
                        if (hdr_idx == 3'(HDR_LEN - 1)) begin
                            state <= DATA;
                        end else begin
                            hdr_idx <= hdr_idx + 3'd1;
                        end
                    end
                end
                DATA: begin
                    if (fb_rd) begin
                        reads_left <= reads_left - CNT_W'(1);
                        if (col == win_ce) begin
                            col <= win_cs;
                            if (page != win_pe) begin
                                page <= page + 3'd1;
                            end
                        end else begin
                            col <= col + 7'd1;
                        end
                    end
                    if (last_byte) begin
                        oled_cs <= 1'b1;
                        done    <= 1'b1;
                        state   <= FINISH;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
